kong_move_ctrl: RTL and testbench
=================================

# kong_move_ctrl

Per-frame motion controller for the Kong player sprite. Consumes the player keys, the rope/platform collision flags from the object-collision stage and the frame strobe, and produces Kong's top-left screen location, movement state, facing direction and icon. Sits directly upstream of the Kong bitmap/draw stage, which consumes its `kong_pkg` typed outputs (`location`, `kong_state`, `kong_icon`, `kong_direction`).

## Interface
- `INIT_X`, 64: reset X (location).
- `INIT_Y`, 416: reset Y (location).
- `WALK_SPEED`, 2: horizontal px/frame.
- `CLIMB_SPEED`, 1: vertical px/frame on rope.
- `JUMP_VY`, -8: initial vertical velocity of a floor jump (px/frame, negative is up).
- `GRAVITY`, 1: vy increment per airborne frame.
- `MAX_FALL`, 8: vy saturation.
- `ANIM_FRAMES`, 8: frames per climb-icon toggle.
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per video frame.
- `key_left`, `key_right`, `key_up`, `key_down`, `key_jump` in 1 each: level keys.
- `platform_edge` in 4: Kong/platform collision, indexed by `E_LEFT`, `E_TOP`, `E_RIGHT`, `E_BOTTOM`.
- `on_rope` in 1: Kong overlaps a rope this pixel.
- `topLeftX`, `topLeftY` out `location` (11-bit signed): sprite position.
- `state` out `kong_state`.
- `icon` out `kong_icon`.
- `direction` out `kong_direction`.

## Operation
- Collision latches: `platform_edge` bits and `on_rope` are OR-accumulated every cycle. On `startOfFrame` the update uses latch OR current-cycle value; latches then clear.
- Keys are sampled only in the `startOfFrame` cycle. Left+right together means no horizontal input and leaves direction unchanged. Otherwise direction follows the pressed key.
- Internal registers: vx (signed 4b), vy (signed 6b), animation counter.
- Airborne physics, each frame in order: y += vy, then vy = min(vy+GRAVITY, MAX_FALL). Also x += vx.
- STANDING:
  - jump → JUMPING, vy=JUMP_VY, vx=±WALK_SPEED per key, else 0.
  - Else up with rope latched → CLIMBING.
  - Else walk by ±WALK_SPEED, blocked if the `E_LEFT`/`E_RIGHT` latch is set in the direction of travel.
  - No `E_BOTTOM` latch → JUMPING with vy=0, vx=0 (fall).
- JUMPING:
  - vy<0 and `E_TOP` latched → JUMPING_IN_PLATFORM.
  - vy>0 and `E_BOTTOM` latched → STANDING, vy=0; no move that frame.
- JUMPING_IN_PLATFORM: same physics, but landing is disabled. A frame with no edge latched → JUMPING.
- CLIMBING:
  - x frozen.
  - up: y −= CLIMB_SPEED. down: y += CLIMB_SPEED.
  - down with `E_BOTTOM` latched → STANDING.
  - jump with left/right → JUMPING_FROM_ROPE, vy=JUMP_VY/2 (arithmetic shift), vx=±WALK_SPEED.
  - Rope not latched → JUMPING_FROM_ROPE, vy=0, vx=0.
- JUMPING_FROM_ROPE: JUMPING physics and landing. Also, vy≥0 with up and rope latched → CLIMBING, vy=0.
- Clamp: x is limited to [0, SCREEN_WIDTH−KONG_WIDTH]=[0,576]. y>SCREEN_HIGHT−KONG_HIGHT=448 clamps to 448 and counts as landing (→ STANDING). y<0 clamps to 0 with vy=0.
- Icon:
  - STANDING: walking → KONG_WALK_LEFT/RIGHT, else KONG_STAND.
  - Airborne states → KONG_JUMP_LEFT/RIGHT by direction.
  - CLIMBING → CLIMB_LEFT/RIGHT, toggling every ANIM_FRAMES frames while moving. The counter clears on entry to CLIMBING.

## Timing
- All outputs registered. The update takes effect on the clock edge ending the `startOfFrame` cycle, so outputs are valid from the next cycle for the whole frame.
- Outputs hold between strobes.
- Reset values: topLeftX=INIT_X, topLeftY=INIT_Y, state=KONG_IS_STANDING, icon=KONG_STAND, direction=KONG_LOOK_RIGHT, vx=vy=0, latches and anim counter clear.
- Reset mid-jump returns immediately to reset values (asynchronous).
- An edge that arrives in the same cycle as `startOfFrame` is used for that update and not carried over.

## Configuration
- `KONG_AIR_CONTROL_EN`
  - Defined: in the three airborne states, vx is recomputed every frame from left/right (±WALK_SPEED/2, 0 if none or both), and direction updates.
  - Undefined: vx is locked at takeoff value and direction frozen while airborne.

## Test plan
- Reset, no keys, `E_BOTTOM` asserted each frame for 10 frames → X=64, Y=416, STANDING, KONG_STAND, LOOK_RIGHT.
- key_right 5 frames with `E_BOTTOM` → X=74, KONG_WALK_RIGHT. Then also assert `E_RIGHT` for 3 frames → X stays 74.
- Jump from Y=416, `E_BOTTOM` asserted throughout → Y=408 after frame 1, Y=380 at frames 8–9, Y=416 at frame 17. Frame 18 → STANDING, vy=0. Assert `resetN` low mid-ascent → immediate reset values.
- `on_rope` + key_up 10 frames → CLIMBING, Y=406, icon toggles CLIMB_LEFT↔CLIMB_RIGHT after 8 frames. Drop `on_rope` → JUMPING_FROM_ROPE, Y increases 0,1,2… per frame.
- From X=2, key_left 3 frames → X=0, never negative. From X=574, key_right → X=576.
- Jump with key_right, then press key_left while airborne → with `KONG_AIR_CONTROL_EN` X decreases by 1/frame and direction flips. Without it, X increases by 2/frame and direction stays LOOK_RIGHT.

Source files
------------

// File: rtl/kong_move_ctrl.sv
// kong_move_ctrl: per-frame Kong sprite motion FSM (walk, jump, climb, screen clamp).
// Optional KONG_AIR_CONTROL_EN: left/right steering while airborne.
package kong_pkg;
    typedef logic signed [10:0] location;
    typedef enum logic [2:0] {
        KONG_IS_STANDING, KONG_IS_JUMPING, KONG_IS_JUMPING_IN_PLATFORM,
        KONG_IS_CLIMBING, KONG_IS_JUMPING_FROM_ROPE
    } kong_state;
    typedef enum logic [2:0] {
        KONG_STAND, KONG_WALK_LEFT, KONG_WALK_RIGHT, KONG_JUMP_LEFT, KONG_JUMP_RIGHT,
        CLIMB_LEFT, CLIMB_RIGHT
    } kong_icon;
    typedef enum logic {KONG_LOOK_LEFT, KONG_LOOK_RIGHT} kong_direction;
    localparam int E_LEFT = 0, E_TOP = 1, E_RIGHT = 2, E_BOTTOM = 3;
    localparam int SCREEN_WIDTH = 640, SCREEN_HIGHT = 480, KONG_WIDTH = 64, KONG_HIGHT = 32;
endpackage

module kong_move_ctrl
    import kong_pkg::*;
#(
    parameter int INIT_X      = 64,
    parameter int INIT_Y      = 416,
    parameter int WALK_SPEED  = 2,
    parameter int CLIMB_SPEED = 1,
    parameter int JUMP_VY     = -8,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL    = 8,
    parameter int ANIM_FRAMES = 8
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          startOfFrame,
    input  logic          key_left,
    input  logic          key_right,
    input  logic          key_up,
    input  logic          key_down,
    input  logic          key_jump,
    input  logic [3:0]    platform_edge,
    input  logic          on_rope,
    output location       topLeftX,
    output location       topLeftY,
    output kong_state     state,
    output kong_icon      icon,
    output kong_direction direction
);
    localparam location X_MAX = 11'(SCREEN_WIDTH - KONG_WIDTH);
    localparam location Y_MAX = 11'(SCREEN_HIGHT - KONG_HIGHT);
    localparam location D_CLIMB = 11'(CLIMB_SPEED);
    localparam logic signed [3:0] V_WALK = 4'(WALK_SPEED);
    localparam logic signed [5:0] V_JUMP = 6'(JUMP_VY);
    localparam logic signed [5:0] V_ROPE = V_JUMP >>> 1;
    localparam logic signed [5:0] V_GRAV = 6'(GRAVITY);
    localparam logic signed [5:0] V_MAX = 6'(MAX_FALL);
    localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);
`ifdef KONG_AIR_CONTROL_EN
    localparam logic signed [3:0] V_AIR = 4'(WALK_SPEED / 2);
`endif

    logic [3:0] edge_lat, edge_now;
    logic rope_lat, rope_now;
    logic signed [3:0] vx, vx_n, v_key;
    logic signed [5:0] vy, vy_n, vy_g;
    logic [7:0] anim, anim_n;
    location x_n, y_n;
    kong_state state_n;
    kong_icon icon_n;
    kong_direction dir_n, dir_key;
    logic hor, air, walking, toggle;

    assign edge_now = edge_lat | platform_edge;
    assign rope_now = rope_lat | on_rope;
    assign hor = key_left ^ key_right;
    assign dir_key = key_right ? KONG_LOOK_RIGHT : KONG_LOOK_LEFT;
    assign v_key = hor ? (key_right ? V_WALK : -V_WALK) : '0;
    assign air = state != KONG_IS_STANDING && state != KONG_IS_CLIMBING;

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            topLeftX  <= 11'(INIT_X);
            topLeftY  <= 11'(INIT_Y);
            state     <= KONG_IS_STANDING;
            icon      <= KONG_STAND;
            direction <= KONG_LOOK_RIGHT;
            vx        <= '0;
            vy        <= '0;
            anim      <= '0;
            edge_lat  <= '0;
            rope_lat  <= 1'b0;
        end else begin
            topLeftX  <= x_n;
            topLeftY  <= y_n;
            state     <= state_n;
            icon      <= icon_n;
            direction <= dir_n;
            vx        <= vx_n;
            vy        <= vy_n;
            anim      <= anim_n;
            edge_lat  <= startOfFrame ? '0 : edge_now;
            rope_lat  <= startOfFrame ? 1'b0 : rope_now;
        end

    always_comb begin
        state_n = state;
        x_n = topLeftX;
        y_n = topLeftY;
        vx_n = vx;
        vy_n = vy;
        vy_g = '0;
        anim_n = anim;
        dir_n = direction;
        icon_n = icon;
        walking = 1'b0;
        toggle = 1'b0;
        if (startOfFrame) begin
            if (hor && !air) dir_n = dir_key;
`ifdef KONG_AIR_CONTROL_EN
            if (air) begin
                vx_n = hor ? (key_right ? V_AIR : -V_AIR) : '0;
                if (hor) dir_n = dir_key;
            end
`endif
            case (state)
                KONG_IS_STANDING:
                    if (key_jump) begin
                        state_n = KONG_IS_JUMPING;
                        vy_n = V_JUMP;
                        vx_n = v_key;
                    end else if (key_up && rope_now) begin
                        state_n = KONG_IS_CLIMBING;
                        anim_n = '0;
                        y_n = topLeftY - D_CLIMB;
                    end else begin
                        walking = hor && !(key_right ? edge_now[E_RIGHT] : edge_now[E_LEFT]);
                        if (walking) x_n = topLeftX + 11'(v_key);
                        if (!edge_now[E_BOTTOM]) begin
                            state_n = KONG_IS_JUMPING;
                            vy_n = '0;
                            vx_n = '0;
                        end
                    end
                KONG_IS_JUMPING:
                    if (!vy[5] && vy != '0 && edge_now[E_BOTTOM]) begin
                        state_n = KONG_IS_STANDING;
                        vy_n = '0;
                        vx_n = '0;
                    end else if (vy[5] && edge_now[E_TOP]) state_n = KONG_IS_JUMPING_IN_PLATFORM;
                KONG_IS_JUMPING_IN_PLATFORM:
                    if (edge_now == '0) state_n = KONG_IS_JUMPING;
                KONG_IS_JUMPING_FROM_ROPE:
                    if (!vy[5] && vy != '0 && edge_now[E_BOTTOM]) begin
                        state_n = KONG_IS_STANDING;
                        vy_n = '0;
                        vx_n = '0;
                    end else if (!vy[5] && key_up && rope_now) begin
                        state_n = KONG_IS_CLIMBING;
                        vy_n = '0;
                        vx_n = '0;
                        anim_n = '0;
                    end
                KONG_IS_CLIMBING:
                    if (!rope_now) begin
                        state_n = KONG_IS_JUMPING_FROM_ROPE;
                        vy_n = '0;
                        vx_n = '0;
                    end else if (key_jump && hor) begin
                        state_n = KONG_IS_JUMPING_FROM_ROPE;
                        vy_n = V_ROPE;
                        vx_n = v_key;
                    end else if (key_down && edge_now[E_BOTTOM]) state_n = KONG_IS_STANDING;
                    else if (key_up || key_down) begin
                        y_n = key_up ? topLeftY - D_CLIMB : topLeftY + D_CLIMB;
                        toggle = anim == ANIM_LAST;
                        anim_n = toggle ? '0 : anim + 8'd1;
                    end
                default: ;
            endcase
            // Entering or staying airborne applies physics in the same frame.
            if (state_n != KONG_IS_STANDING && state_n != KONG_IS_CLIMBING) begin
                y_n = y_n + 11'(vy_n);
                vy_g = vy_n + V_GRAV;
                vy_n = vy_g > V_MAX ? V_MAX : vy_g;
                x_n = x_n + 11'(vx_n);
            end
            x_n = x_n[10] ? '0 : x_n > X_MAX ? X_MAX : x_n;
            if (y_n > Y_MAX) begin
                y_n = Y_MAX;
                state_n = KONG_IS_STANDING;
                vy_n = '0;
                vx_n = '0;
            end else if (y_n[10]) begin
                y_n = '0;
                vy_n = '0;
            end
            icon_n = state_n == KONG_IS_STANDING
                       ? (walking ? (dir_n == KONG_LOOK_RIGHT ? KONG_WALK_RIGHT : KONG_WALK_LEFT) : KONG_STAND)
                   : state_n == KONG_IS_CLIMBING
                       ? (state != KONG_IS_CLIMBING ? (dir_n == KONG_LOOK_RIGHT ? CLIMB_RIGHT : CLIMB_LEFT)
                          : toggle ? (icon == CLIMB_RIGHT ? CLIMB_LEFT : CLIMB_RIGHT) : icon)
                   : (dir_n == KONG_LOOK_RIGHT ? KONG_JUMP_RIGHT : KONG_JUMP_LEFT);
        end
    end
endmodule

// File: tb/tb_kong_move_ctrl.sv
// tb_kong_move_ctrl: directed and random frames checked against a frame-level model of Kong's motion.
module tb_kong_move_ctrl;
    import kong_pkg::*;
    localparam int WALK = 2, CLIMB = 1, JUMP_VY = -8, GRAV = 1, MAX_FALL = 8, ANIM = 8;
    localparam int XMAX = 576, YMAX = 448, FLOOR = 416;
    localparam logic [4:0] K_L = 5'b00001, K_R = 5'b00010, K_U = 5'b00100, K_J = 5'b10000;
    localparam logic [3:0] B_BOT = 4'b1000, B_RIGHT = 4'b0100;
`ifdef KONG_AIR_CONTROL_EN
    localparam bit AIR = 1'b1;
`else
    localparam bit AIR = 1'b0;
`endif

    logic clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0;
    logic key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0, key_jump = 1'b0;
    logic [3:0] platform_edge = '0;
    logic on_rope = 1'b0;
    location topLeftX, topLeftY;
    kong_state state;
    kong_icon icon;
    kong_direction direction;

    int checks = 0, errors = 0;
    int mx, my, mvx, mvy, manim;
    kong_state ms;
    kong_icon mi;
    kong_direction md;

    kong_move_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
        .key_jump(key_jump), .platform_edge(platform_edge), .on_rope(on_rope),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .state(state), .icon(icon), .direction(direction)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("x", topLeftX, mx);
        chk("y", topLeftY, my);
        chk("state", state, ms);
        chk("icon", icon, mi);
        chk("direction", direction, md);
    endtask

    task automatic model_reset();
        mx = 64; my = 416; mvx = 0; mvy = 0; manim = 0;
        ms = KONG_IS_STANDING; mi = KONG_STAND; md = KONG_LOOK_RIGHT;
    endtask

    // One frame of Kong rules: k = {jump,down,up,right,left}, e/r = everything seen during the frame.
    task automatic model_step(input logic [4:0] k, input logic [3:0] e, input logic r);
        int h;
        bit was_air, walked, tog;
        kong_state ns;
        h = (k[1] && !k[0]) ? 1 : (k[0] && !k[1]) ? -1 : 0;
        was_air = ms inside {KONG_IS_JUMPING, KONG_IS_JUMPING_IN_PLATFORM, KONG_IS_JUMPING_FROM_ROPE};
        ns = ms; walked = 0; tog = 0;
        if (h != 0 && (!was_air || AIR)) md = h > 0 ? KONG_LOOK_RIGHT : KONG_LOOK_LEFT;
        if (was_air && AIR) mvx = h * (WALK / 2);
        if ((ms == KONG_IS_JUMPING || ms == KONG_IS_JUMPING_FROM_ROPE) && mvy > 0 && e[E_BOTTOM]) begin
            ns = KONG_IS_STANDING; mvy = 0; mvx = 0;
        end else case (ms)
            KONG_IS_STANDING:
                if (k[4]) begin
                    ns = KONG_IS_JUMPING; mvy = JUMP_VY; mvx = h * WALK;
                end else if (k[2] && r) begin
                    ns = KONG_IS_CLIMBING; manim = 0; my -= CLIMB;
                end else begin
                    walked = h != 0 && !e[h > 0 ? E_RIGHT : E_LEFT];
                    mx += walked ? h * WALK : 0;
                    if (!e[E_BOTTOM]) begin ns = KONG_IS_JUMPING; mvy = 0; mvx = 0; end
                end
            KONG_IS_JUMPING: if (mvy < 0 && e[E_TOP]) ns = KONG_IS_JUMPING_IN_PLATFORM;
            KONG_IS_JUMPING_IN_PLATFORM: if (e == 0) ns = KONG_IS_JUMPING;
            KONG_IS_JUMPING_FROM_ROPE:
                if (mvy >= 0 && k[2] && r) begin
                    ns = KONG_IS_CLIMBING; mvy = 0; mvx = 0; manim = 0;
                end
            default:
                if (!r) begin
                    ns = KONG_IS_JUMPING_FROM_ROPE; mvy = 0; mvx = 0;
                end else if (k[4] && h != 0) begin
                    ns = KONG_IS_JUMPING_FROM_ROPE; mvy = JUMP_VY / 2; mvx = h * WALK;
                end else if (k[3] && e[E_BOTTOM]) ns = KONG_IS_STANDING;
                else if (k[2] || k[3]) begin
                    my += k[2] ? -CLIMB : CLIMB;
                    manim++;
                    if (manim == ANIM) begin manim = 0; tog = 1; end
                end
        endcase
        if (!(ns inside {KONG_IS_STANDING, KONG_IS_CLIMBING})) begin
            my += mvy;
            mvy = (mvy + GRAV > MAX_FALL) ? MAX_FALL : mvy + GRAV;
            mx += mvx;
        end
        if (mx < 0) mx = 0;
        if (mx > XMAX) mx = XMAX;
        if (my > YMAX) begin
            my = YMAX; ns = KONG_IS_STANDING; mvy = 0; mvx = 0;
        end else if (my < 0) begin
            my = 0; mvy = 0;
        end
        if (ns == KONG_IS_STANDING)
            mi = walked ? (md == KONG_LOOK_RIGHT ? KONG_WALK_RIGHT : KONG_WALK_LEFT) : KONG_STAND;
        else if (ns == KONG_IS_CLIMBING)
            mi = ms != KONG_IS_CLIMBING ? (md == KONG_LOOK_RIGHT ? CLIMB_RIGHT : CLIMB_LEFT)
               : tog ? (mi == CLIMB_RIGHT ? CLIMB_LEFT : CLIMB_RIGHT) : mi;
        else
            mi = md == KONG_LOOK_RIGHT ? KONG_JUMP_RIGHT : KONG_JUMP_LEFT;
        ms = ns;
    endtask

    // Frame = 4 quiet cycles then the strobe; ep/rp arrive mid-frame, es/rs with the strobe.
    task automatic frame(input logic [4:0] k, input logic [3:0] ep, input logic rp,
                         input logic [3:0] es, input logic rs);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                chk("hold_x", topLeftX, mx);
                chk("hold_state", state, ms);
            end
            startOfFrame = c == 3;
            {key_jump, key_down, key_up, key_right, key_left} = c == 3 ? k : 5'($urandom);
            platform_edge = c == 1 ? ep : c == 3 ? es : 4'b0;
            on_rope = c == 1 ? rp : c == 3 ? rs : 1'b0;
        end
        @(negedge clk);
        startOfFrame = 1'b0;
        {key_jump, key_down, key_up, key_right, key_left} = 5'($urandom);
        platform_edge = '0;
        on_rope = 1'b0;
        model_step(k, ep | es, rp | rs);
        chk_all();
    endtask

    function automatic logic [3:0] floor_edge();
        return my >= FLOOR ? B_BOT : 4'b0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_x", topLeftX, 64);
        chk("rst_y", topLeftY, 416);
        chk("rst_state", state, KONG_IS_STANDING);
        chk("rst_icon", icon, KONG_STAND);
        chk("rst_dir", direction, KONG_LOOK_RIGHT);
        resetN = 1'b1;

        repeat (10) frame('0, '0, 1'b0, B_BOT, 1'b0);
        chk("idle_x", topLeftX, 64);
        chk("idle_y", topLeftY, 416);
        chk("idle_icon", icon, KONG_STAND);

        repeat (5) frame(K_R, B_BOT, 1'b0, '0, 1'b0);
        chk("walk_x", topLeftX, 74);
        chk("walk_icon", icon, KONG_WALK_RIGHT);
        repeat (3) frame(K_R, B_RIGHT, 1'b0, B_BOT, 1'b0);
        chk("blocked_x", topLeftX, 74);

        for (int f = 1; f <= 18; f++) begin
            frame(f == 1 ? K_J : 5'b0, '0, 1'b0, floor_edge(), 1'b0);
            if (f == 1) chk("jump_y1", topLeftY, 408);
            if (f == 8 || f == 9) chk("jump_apex", topLeftY, 380);
            if (f == 17) chk("jump_y17", topLeftY, 416);
            if (f == 18) chk("jump_land", state, KONG_IS_STANDING);
        end

        frame(K_J, '0, 1'b0, B_BOT, 1'b0);
        repeat (2) frame('0, '0, 1'b0, '0, 1'b0);
        chk("ascent_y", topLeftY, 395);
        #2 resetN = 1'b0;
        #1;
        chk("async_rst_x", topLeftX, 64);
        chk("async_rst_y", topLeftY, 416);
        chk("async_rst_state", state, KONG_IS_STANDING);
        chk("async_rst_icon", icon, KONG_STAND);
        model_reset();
        @(negedge clk);
        resetN = 1'b1;

        for (int f = 1; f <= 10; f++) begin
            frame(K_U, '0, 1'b1, floor_edge(), 1'b0);
            if (f == 1) chk("climb_enter", state, KONG_IS_CLIMBING);
            if (f == 8) chk("climb_icon8", icon, CLIMB_RIGHT);
            if (f == 9) chk("climb_icon9", icon, CLIMB_LEFT);
            if (f == 10) chk("climb_y", topLeftY, 406);
        end
        for (int f = 1; f <= 3; f++) begin
            frame('0, '0, 1'b0, floor_edge(), 1'b0);
            chk("rope_drop_state", state, KONG_IS_JUMPING_FROM_ROPE);
            chk("rope_drop_y", topLeftY, f == 1 ? 406 : f == 2 ? 407 : 409);
        end
        repeat (6) frame('0, '0, 1'b0, floor_edge(), 1'b0);

        do_reset();
        repeat (31) frame(K_L, '0, 1'b0, B_BOT, 1'b0);
        chk("left_x2", topLeftX, 2);
        for (int f = 0; f < 3; f++) begin
            frame(K_L, '0, 1'b0, B_BOT, 1'b0);
            chk("left_clamp", topLeftX, 0);
        end
        repeat (287) frame(K_R, '0, 1'b0, B_BOT, 1'b0);
        chk("right_x574", topLeftX, 574);
        for (int f = 0; f < 2; f++) begin
            frame(K_R, '0, 1'b0, B_BOT, 1'b0);
            chk("right_clamp", topLeftX, 576);
        end

        do_reset();
        frame(K_J | K_R, '0, 1'b0, B_BOT, 1'b0);
        chk("air_takeoff_x", topLeftX, 66);
        for (int f = 1; f <= 4; f++) begin
            frame(K_L, '0, 1'b0, '0, 1'b0);
            chk("air_x", topLeftX, AIR ? 66 - f : 66 + 2 * f);
            chk("air_dir", direction, AIR ? KONG_LOOK_LEFT : KONG_LOOK_RIGHT);
        end
        repeat (16) frame('0, '0, 1'b0, floor_edge(), 1'b0);

        repeat (400) begin
            logic [3:0] es;
            es = 4'($urandom) & 4'($urandom);
            if (my >= FLOOR && $urandom_range(0, 3) != 0) es |= B_BOT;
            frame(5'($urandom), 4'($urandom) & 4'($urandom), 1'($urandom_range(0, 1)),
                  es, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
